// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer
//   Command front end for sr_latch. Two raw pushbuttons (set, reset) are
//   synchronised and debounced. Each debounced press becomes a one-cycle s/r
//   command pulse. s_out and r_out are never high in the same cycle. After a
//   command, a lockout gap drops further presses.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive cycles the synced level must differ (>=1)
//   GAP_CYCLES       lockout length, counting the pulse cycle (>=0)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   btn_set   raw set button (asynchronous, bouncy)
//   btn_rst   raw reset button (asynchronous, bouncy)
//   s_out     one-cycle set command
//   r_out     one-cycle reset command
//   busy      lockout active; presses seen now are dropped
//   conflict  one-cycle flag: both presses arrived together in IDLE, both dropped
//   drop_cnt  saturating 8-bit count of cycles with a drop (SRCMD_STATS_EN only)
//
// Build option
//   SRCMD_STATS_EN  adds the drop_cnt port and its counter.

// One button channel: 2-flop synchroniser, debounce counter, rising-edge event.
module sr_cmd_deb_chan #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic evt
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic          synced;
   logic [CW-1:0] cnt;
   logic          deb;
   logic          deb_d;

   assign synced = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], raw};
      end
   end

   // The counter tracks how long synced has disagreed with deb. The edge that
   // would take it to DEBOUNCE_CYCLES instead flips deb and restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         deb   <= 1'b0;
         deb_d <= 1'b0;
      end else begin
         deb_d <= deb;
         if (synced != deb) begin
            if (cnt == CNT_LAST) begin
               deb <= synced;
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   // Presses only; releases produce nothing.
   assign evt = deb & ~deb_d;
endmodule

module sr_cmd_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_set,
   input  logic       btn_rst,
   output logic       s_out,
   output logic       r_out,
   output logic       busy,
   output logic       conflict
`ifdef SRCMD_STATS_EN
   ,
   output logic [7:0] drop_cnt
`endif
);
   localparam int NUM_CH = 2;
   localparam int GW     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);
   localparam logic          HAS_GAP  = (GAP_CYCLES > 0);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_GAP  = 1'b1;

   // Channel 0 = set, channel 1 = reset.
   logic [NUM_CH-1:0] btn_raw;
   logic [NUM_CH-1:0] evt;

   assign btn_raw = {btn_rst, btn_set};

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
      sr_cmd_deb_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .raw  (btn_raw[ch]),
         .evt  (evt[ch])
      );
   end

   logic [0:0]    state;
   logic [GW-1:0] gap_cnt;
   logic          in_idle;
   logic          one_s;
   logic          one_r;
   logic          both;

   always_comb begin
      in_idle = (state == ST_IDLE);
      both    = evt[0] & evt[1];
      one_s   = evt[0] & ~evt[1];
      one_r   = evt[1] & ~evt[0];
   end

   assign busy = (state == ST_GAP);

   // Outputs are registered; a pulse only ever comes from a single event seen
   // in IDLE, so s_out and r_out are mutually exclusive by construction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_out    <= 1'b0;
         r_out    <= 1'b0;
         conflict <= 1'b0;
      end else begin
         s_out    <= in_idle & one_s;
         r_out    <= in_idle & one_r;
         conflict <= in_idle & both;
      end
   end

   // gap_cnt is loaded with GAP_CYCLES on the pulse edge, so busy covers the
   // pulse cycle plus GAP_CYCLES-1 more.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         gap_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if ((one_s | one_r) && HAS_GAP) begin
                  state   <= ST_GAP;
                  gap_cnt <= GAP_INIT;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GW'(1)) begin
                  state <= ST_IDLE;
               end
               gap_cnt <= gap_cnt - GW'(1);
            end
            default: begin
               state   <= ST_IDLE;
               gap_cnt <= '0;
            end
         endcase
      end
   end

`ifdef SRCMD_STATS_EN
   // A drop is a simultaneous pair in IDLE, or any press during the gap.
   // At most one count per cycle.
   logic drop;

   always_comb begin
      drop = in_idle ? both : (|evt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= 8'd0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// Bench for sr_cmd_debouncer with DEBOUNCE_CYCLES=4, GAP_CYCLES=2.
// Each vector drives both buttons and is checked 1 time unit after the next
// rising edge. Vector k's expected outputs therefore describe the cycle
// after edge k. drop_cnt checks are present only when SRCMD_STATS_EN is set.
module tb_sr_cmd_debouncer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_set = 1'b0;
   logic btn_rst = 1'b0;
   logic s_out, r_out, busy, conflict;
`ifdef SRCMD_STATS_EN
   logic [7:0] drop_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sr_cmd_debouncer #(
      .DEBOUNCE_CYCLES(4),
      .GAP_CYCLES     (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_set (btn_set),
      .btn_rst (btn_rst),
      .s_out   (s_out),
      .r_out   (r_out),
      .busy    (busy),
      .conflict(conflict)
`ifdef SRCMD_STATS_EN
      ,
      .drop_cnt(drop_cnt)
`endif
   );

   typedef struct {
      bit set;
      bit rst;
      bit s;
      bit r;
      bit b;
      bit c;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_run(input int n, input bit set, input bit rst);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.set = set; v.rst = rst;
         v.s = 0; v.r = 0; v.b = 0; v.c = 0;
         tbl.push_back(v);
      end
   endtask

   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         btn_set = tbl[i].set;
         btn_rst = tbl[i].rst;
         @(posedge clk);
         #1;
         chk($sformatf("%s[%0d] {s,r,busy,conflict}", name, i),
             int'({s_out, r_out, busy, conflict}),
             int'({tbl[i].s, tbl[i].r, tbl[i].b, tbl[i].c}));
      end
      tbl.delete();
   endtask

   task automatic step(input bit set, input bit rst);
      btn_set = set;
      btn_rst = rst;
      @(posedge clk);
      #1;
   endtask

   // s_out and r_out must never be high together.
   always @(negedge clk) begin
      n_tests++;
      if (s_out === 1'b1 && r_out === 1'b1) begin
         n_fail++;
         $display("FAIL s_r_exclusive: s_out=%b r_out=%b both high", s_out, r_out);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int n_conf;
      bit stray;

      // Reset held for 3 edges.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", int'({s_out, r_out, busy, conflict}), 0);
`ifdef SRCMD_STATS_EN
      chk("reset_drop_cnt", int'(drop_cnt), 0);
`endif
      rst_n = 1'b1;

      // 1: idle after reset.
      add_run(20, 0, 0);
      // 2: clean set press, held 12 cycles, then released.
      b = tbl.size();
      add_run(12, 1, 0);
      add_run(13, 0, 0);
      tbl[b+6].s = 1; tbl[b+6].b = 1;
      tbl[b+7].b = 1;
      // 3: bouncy reset button, stable run starts at vector 7.
      b = tbl.size();
      add_run(2, 0, 1);
      add_run(1, 0, 0);
      add_run(3, 0, 1);
      add_run(1, 0, 0);
      add_run(14, 0, 1);
      add_run(10, 0, 0);
      tbl[b+13].r = 1; tbl[b+13].b = 1;
      tbl[b+14].b = 1;
      run_table("basic");
`ifdef SRCMD_STATS_EN
      chk("drop_cnt_after_basic", int'(drop_cnt), 0);
`endif

      // 4: simultaneous presses -> conflict only.
      add_run(11, 1, 1);
      add_run(10, 0, 0);
      tbl[6].c = 1;
      run_table("conflict");
`ifdef SRCMD_STATS_EN
      chk("drop_cnt_after_conflict", int'(drop_cnt), 1);
`endif

      // 5: reset press lands in the last gap cycle and is dropped; a later
      // reset press in IDLE goes through.
      add_run(2, 1, 0);
      add_run(8, 1, 1);
      add_run(10, 0, 0);
      add_run(10, 0, 1);
      add_run(10, 0, 0);
      tbl[6].s = 1;  tbl[6].b = 1;
      tbl[7].b = 1;
      tbl[26].r = 1; tbl[26].b = 1;
      tbl[27].b = 1;
      run_table("gap_drop");
`ifdef SRCMD_STATS_EN
      chk("drop_cnt_after_gap_drop", int'(drop_cnt), 2);
`endif

      // 6a: async reset during the s_out pulse.
      for (int i = 0; i < 7; i++) step(1, 0);
      chk("pulse_before_async_reset", int'({s_out, busy}), 3);
      #1;
      rst_n = 1'b0;
      btn_set = 1'b0;
      #1;
      chk("async_reset_kills_pulse", int'({s_out, r_out, busy, conflict}), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
`ifdef SRCMD_STATS_EN
      chk("drop_cnt_cleared_by_reset", int'(drop_cnt), 0);
`endif
      rst_n = 1'b1;
      add_run(12, 0, 0);
      run_table("post_reset_idle");

      // 6b: 260 forced conflicts; drop_cnt saturates at 255.
      n_conf = 0;
      stray  = 0;
      for (int k = 0; k < 260; k++) begin
         for (int i = 0; i < 16; i++) begin
            step(i < 8, i < 8);
            if (conflict) n_conf++;
            if (s_out || r_out || busy) stray = 1;
         end
`ifdef SRCMD_STATS_EN
         if (k == 99) chk("drop_cnt_at_100", int'(drop_cnt), 100);
`endif
      end
      chk("conflict_pulses", n_conf, 260);
      chk("no_cmd_during_conflicts", int'(stray), 0);
`ifdef SRCMD_STATS_EN
      chk("drop_cnt_saturated", int'(drop_cnt), 255);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
